// File: rtl/id_exe_stage.sv
// rtl/id_exe_stage.sv - ID/EX pipeline register with load-use hazard tracker
//
// Purpose:
//   Captures decoded operands and control from ID into the EX stage register.
//   On every rising edge the register does one of four things, in priority order:
//     1. flush  - a redirect kills the instruction entering EX (NOP bubble)
//     2. hold   - both ID and EX are stopped, so everything is frozen
//     3. bubble - ID is stopped but EX is free, so a NOP enters EX
//     4. advance - the ID instruction moves into EX
//   A small shift register follows loads as they leave EX. stall_req_o is raised
//   combinationally when the instruction in ID reads a register that one of
//   those loads has not yet produced.
//
// Optional feature:
//   ID_EXE_PERF_CNT_EN - adds bubble_cnt_o, a wrapping count of the edges that
//   insert a bubble (flush or bubble case). Without the macro the port and the
//   counter do not exist.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   stall_i        per-stage stop vector; bit STAGE = ID, bit STAGE+1 = EX
//   flush_i        redirect; kills the instruction entering EX
//   op1_i, op2_i   operands from ID
//   reg_we_i       register write enable from ID
//   reg_waddr_i    destination register from ID
//   inst_i         instruction in ID
//   rs1_re_i       ID really reads rs1 (inst_i[19:15])
//   rs2_re_i       ID really reads rs2 (inst_i[24:20])
//   op1_o, op2_o   registered operands
//   reg_we_o       registered write enable
//   reg_waddr_o    registered destination register
//   inst_o         registered instruction (NOP after reset, flush or bubble)
//   inst_is_load_o EX holds a load
//   rd_o           registered inst[11:7]
//   bubble_cnt_o   inserted-bubble count (ID_EXE_PERF_CNT_EN only)
//   stall_req_o    combinational load-use stall request

module id_exe_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int RDATA_WIDTH = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int STALL_W     = 6,
  parameter int STAGE       = 2,
  parameter int LOAD_LAT    = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [STALL_W-1:0]     stall_i,
  input  logic                   flush_i,
  input  logic [RDATA_WIDTH-1:0] op1_i,
  input  logic [RDATA_WIDTH-1:0] op2_i,
  input  logic                   reg_we_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic [DATA_WIDTH-1:0]  inst_i,
  input  logic                   rs1_re_i,
  input  logic                   rs2_re_i,
  output logic [RDATA_WIDTH-1:0] op1_o,
  output logic [RDATA_WIDTH-1:0] op2_o,
  output logic                   reg_we_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic [DATA_WIDTH-1:0]  inst_o,
  output logic                   inst_is_load_o,
  output logic [RADDR_WIDTH-1:0] rd_o,
`ifdef ID_EXE_PERF_CNT_EN
  output logic [31:0]            bubble_cnt_o,
`endif
  output logic                   stall_req_o
);

  localparam logic [DATA_WIDTH-1:0] NOP_INST = DATA_WIDTH'(32'h0000_0013);
  localparam logic [6:0]            OPC_LOAD = 7'b0000011;

  // Per-edge action of the EX register, in priority order.
  typedef enum logic [1:0] {
    UPD_FLUSH,
    UPD_HOLD,
    UPD_BUBBLE,
    UPD_ADVANCE
  } upd_e;

  logic stall_id;
  logic stall_ex;
  upd_e upd;

  assign stall_id = stall_i[STAGE];
  assign stall_ex = stall_i[STAGE+1];

  // Only the ID and EX bits of the stall vector matter here.
  logic unused_stall;
  assign unused_stall = ^stall_i;

  always_comb begin
    upd = UPD_ADVANCE;
    if (flush_i) begin
      upd = UPD_FLUSH;
    end else if (stall_id && stall_ex) begin
      upd = UPD_HOLD;
    end else if (stall_id) begin
      upd = UPD_BUBBLE;
    end
  end

  // ---------------------------------------------------------------------------
  // EX stage register
  // ---------------------------------------------------------------------------
  logic [RDATA_WIDTH-1:0] op1_q, op1_d;
  logic [RDATA_WIDTH-1:0] op2_q, op2_d;
  logic                   reg_we_q, reg_we_d;
  logic [RADDR_WIDTH-1:0] reg_waddr_q, reg_waddr_d;
  logic [DATA_WIDTH-1:0]  inst_q, inst_d;
  logic                   is_load_q, is_load_d;
  logic [RADDR_WIDTH-1:0] rd_q, rd_d;

  always_comb begin
    op1_d       = op1_q;
    op2_d       = op2_q;
    reg_we_d    = reg_we_q;
    reg_waddr_d = reg_waddr_q;
    inst_d      = inst_q;
    is_load_d   = is_load_q;
    rd_d        = rd_q;
    unique case (upd)
      UPD_FLUSH, UPD_BUBBLE: begin
        op1_d       = '0;
        op2_d       = '0;
        reg_we_d    = 1'b0;
        reg_waddr_d = '0;
        inst_d      = NOP_INST;
        is_load_d   = 1'b0;
        rd_d        = '0;
      end
      UPD_ADVANCE: begin
        op1_d       = op1_i;
        op2_d       = op2_i;
        reg_we_d    = reg_we_i;
        reg_waddr_d = reg_waddr_i;
        inst_d      = inst_i;
        is_load_d   = (inst_i[6:0] == OPC_LOAD);
        rd_d        = RADDR_WIDTH'(inst_i[11:7]);
      end
      default: ;  // UPD_HOLD keeps the defaults
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op1_q       <= '0;
      op2_q       <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      inst_q      <= NOP_INST;
      is_load_q   <= 1'b0;
      rd_q        <= '0;
    end else begin
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      inst_q      <= inst_d;
      is_load_q   <= is_load_d;
      rd_q        <= rd_d;
    end
  end

  assign op1_o          = op1_q;
  assign op2_o          = op2_q;
  assign reg_we_o       = reg_we_q;
  assign reg_waddr_o    = reg_waddr_q;
  assign inst_o         = inst_q;
  assign inst_is_load_o = is_load_q;
  assign rd_o           = rd_q;

  // ---------------------------------------------------------------------------
  // Load tracker
  // Entry 0 is the load currently in EX (taken straight from the EX register,
  // so a flush or bubble clears it for free). Entries 1.. are loads that have
  // left EX but whose data is still not forwardable.
  // ---------------------------------------------------------------------------
  logic [LOAD_LAT-1:0]    ld_vld;
  logic [RADDR_WIDTH-1:0] ld_rd [LOAD_LAT];

  assign ld_vld[0] = is_load_q && (rd_q != '0);
  assign ld_rd[0]  = rd_q;

  generate
    if (LOAD_LAT > 1) begin : g_older
      logic [LOAD_LAT-1:1]    vld_q, vld_d;
      logic [RADDR_WIDTH-1:0] rd_arr_q [1:LOAD_LAT-1];
      logic [RADDR_WIDTH-1:0] rd_arr_d [1:LOAD_LAT-1];

      // Older entries move whenever EX moves; a flush moves EX even when the
      // EX stall bit is set, so the queue keeps draining in that case too.
      always_comb begin
        vld_d = vld_q;
        for (int k = 1; k < LOAD_LAT; k++) begin
          rd_arr_d[k] = rd_arr_q[k];
        end
        if (flush_i || !stall_ex) begin
          for (int k = 1; k < LOAD_LAT; k++) begin
            vld_d[k]    = ld_vld[k-1];
            rd_arr_d[k] = ld_rd[k-1];
          end
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          vld_q <= '0;
          for (int k = 1; k < LOAD_LAT; k++) begin
            rd_arr_q[k] <= '0;
          end
        end else begin
          vld_q <= vld_d;
          for (int k = 1; k < LOAD_LAT; k++) begin
            rd_arr_q[k] <= rd_arr_d[k];
          end
        end
      end

      for (genvar g = 1; g < LOAD_LAT; g++) begin : g_map
        assign ld_vld[g] = vld_q[g];
        assign ld_rd[g]  = rd_arr_q[g];
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic [RADDR_WIDTH-1:0] rs1_addr;
  logic [RADDR_WIDTH-1:0] rs2_addr;
  logic                   stall_req;

  assign rs1_addr = RADDR_WIDTH'(inst_i[19:15]);
  assign rs2_addr = RADDR_WIDTH'(inst_i[24:20]);

  // x0 is excluded on the source side as well; tracker entries with rd=0
  // are already marked invalid.
  always_comb begin
    stall_req = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (ld_vld[k]) begin
        if (rs1_re_i && (rs1_addr == ld_rd[k]) && (rs1_addr != '0)) begin
          stall_req = 1'b1;
        end
        if (rs2_re_i && (rs2_addr == ld_rd[k]) && (rs2_addr != '0)) begin
          stall_req = 1'b1;
        end
      end
    end
  end

  assign stall_req_o = stall_req;

  // ---------------------------------------------------------------------------
  // Optional bubble counter
  // ---------------------------------------------------------------------------
`ifdef ID_EXE_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (upd == UPD_FLUSH || upd == UPD_BUBBLE) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_exe_stage.sv
// tb/tb_id_exe_stage.sv - directed self-checking bench for id_exe_stage
module tb_id_exe_stage;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] LW_X5     = 32'h0000_A283; // lw  x5, 0(x1)
  localparam logic [31:0] LW_X0     = 32'h0000_A003; // lw  x0, 0(x1)
  localparam logic [31:0] ADD_RS1X5 = 32'h0012_8333; // add x6, x5, x1
  localparam logic [31:0] ADD_RS2X5 = 32'h0050_8333; // add x6, x1, x5
  localparam logic [31:0] ADD_X0    = 32'h0000_0333; // add x6, x0, x0

  localparam logic [5:0] ST_RUN    = 6'b000000;
  localparam logic [5:0] ST_BUBBLE = 6'b000100; // ID stop, EX free
  localparam logic [5:0] ST_HOLD   = 6'b001100; // ID and EX stop

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall_a = '0;
  logic [5:0]  stall_b = '0;
  logic        flush = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] inst = '0;
  logic        rs1_re = 1'b0;
  logic        rs2_re = 1'b0;

  logic [31:0] a_op1, a_op2, a_inst, b_op1, b_op2, b_inst;
  logic        a_we, a_ld, a_req, b_we, b_ld, b_req;
  logic [4:0]  a_waddr, a_rd, b_waddr, b_rd;
`ifdef ID_EXE_PERF_CNT_EN
  logic [31:0] a_cnt, b_cnt;
`endif

  always #5 clk = ~clk;

  id_exe_stage #(.LOAD_LAT(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .stall_i(stall_a), .flush_i(flush),
    .op1_i(op1), .op2_i(op2), .reg_we_i(we), .reg_waddr_i(waddr),
    .inst_i(inst), .rs1_re_i(rs1_re), .rs2_re_i(rs2_re),
    .op1_o(a_op1), .op2_o(a_op2), .reg_we_o(a_we), .reg_waddr_o(a_waddr),
    .inst_o(a_inst), .inst_is_load_o(a_ld), .rd_o(a_rd),
`ifdef ID_EXE_PERF_CNT_EN
    .bubble_cnt_o(a_cnt),
`endif
    .stall_req_o(a_req)
  );

  id_exe_stage #(.LOAD_LAT(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .stall_i(stall_b), .flush_i(flush),
    .op1_i(op1), .op2_i(op2), .reg_we_i(we), .reg_waddr_i(waddr),
    .inst_i(inst), .rs1_re_i(rs1_re), .rs2_re_i(rs2_re),
    .op1_o(b_op1), .op2_o(b_op2), .reg_we_o(b_we), .reg_waddr_o(b_waddr),
    .inst_o(b_inst), .inst_is_load_o(b_ld), .rd_o(b_rd),
`ifdef ID_EXE_PERF_CNT_EN
    .bubble_cnt_o(b_cnt),
`endif
    .stall_req_o(b_req)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [31:0] i, input logic r1, input logic r2,
                        input logic [31:0] o1, input logic [31:0] o2,
                        input logic w, input logic [4:0] wa);
    inst = i; rs1_re = r1; rs2_re = r2; op1 = o1; op2 = o2; we = w; waddr = wa;
  endtask

  initial begin
    // Reset with nonzero inputs, applied between edges.
    set_id(LW_X5, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 5'd5);
    #2 rst = 1'b1;
    #1;
    check("rst_inst",  a_inst, NOP);
    check("rst_op1",   a_op1, 0);
    check("rst_we",    a_we, 0);
    check("rst_ld",    a_ld, 0);
    check("rst_req_b", b_req, 0);
    tick();
    #2 rst = 1'b0;

    // Advance a load into EX.
    set_id(LW_X5, 1'b1, 1'b0, 32'h1111_1111, 32'h2222_2222, 1'b1, 5'd5);
    tick();
    check("adv_inst",  a_inst, LW_X5);
    check("adv_ld",    a_ld, 1);
    check("adv_rd",    a_rd, 5);
    check("adv_waddr", a_waddr, 5);
    check("adv_op2",   a_op2, 32'h2222_2222);

    // Dependent add in ID.
    set_id(ADD_RS1X5, 1'b1, 1'b1, 32'h3333_3333, 32'h4444_4444, 1'b1, 5'd6);
    #1;
    check("lu_req_a0", a_req, 1);
    check("lu_req_b0", b_req, 1);

    // First bubble for both.
    stall_a = ST_BUBBLE; stall_b = ST_BUBBLE;
    tick();
    check("lu_bub_inst_a", a_inst, NOP);
    check("lu_bub_we_a",   a_we, 0);
    check("lu_req_a1",     a_req, 0);
    check("lu_req_b1",     b_req, 1);

    // LOAD_LAT=1 advances; LOAD_LAT=2 takes its second bubble.
    stall_a = ST_RUN;
    tick();
    check("lu_adv_inst_a", a_inst, ADD_RS1X5);
    check("lu_bub2_inst_b", b_inst, NOP);
    check("lu_req_b2",     b_req, 0);
`ifdef ID_EXE_PERF_CNT_EN
    check("cnt_a1", a_cnt, 1);
    check("cnt_b2", b_cnt, 2);
`endif
    stall_b = ST_RUN;
    tick();
    check("lu_adv_inst_b", b_inst, ADD_RS1X5);
    check("lu_adv_op1_b",  b_op1, 32'h3333_3333);

    // Hold for three edges with different ID contents.
    set_id(LW_X0, 1'b0, 1'b0, 32'h5555_5555, 32'h6666_6666, 1'b0, 5'd9);
    stall_a = ST_HOLD; stall_b = ST_HOLD;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_inst", a_inst, ADD_RS1X5);
      check("hold_op1",  a_op1, 32'h3333_3333);
      check("hold_we",   a_we, 1);
    end

    // Flush beats hold.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_inst", a_inst, NOP);
    check("flush_we",   a_we, 0);
    check("flush_op1",  a_op1, 0);
`ifdef ID_EXE_PERF_CNT_EN
    check("cnt_a2", a_cnt, 2);
    check("cnt_b3", b_cnt, 3);
`endif

    // lw x0 then a consumer of x0: never a hazard.
    stall_a = ST_RUN; stall_b = ST_RUN;
    set_id(LW_X0, 1'b0, 1'b0, 0, 0, 1'b0, 5'd0);
    tick();
    check("x0_ld", a_ld, 1);
    check("x0_rd", a_rd, 0);
    set_id(ADD_X0, 1'b1, 1'b1, 0, 0, 1'b1, 5'd6);
    #1;
    check("x0_req_a", a_req, 0);
    check("x0_req_b", b_req, 0);

    // lw x5 then consumer that does not read its sources.
    set_id(LW_X5, 1'b0, 1'b0, 0, 0, 1'b1, 5'd5);
    tick();
    set_id(ADD_RS1X5, 1'b0, 1'b0, 0, 0, 1'b1, 5'd6);
    #1;
    check("noread_req", a_req, 0);
    set_id(ADD_RS2X5, 1'b0, 1'b1, 0, 0, 1'b1, 5'd6);
    #1;
    check("rs2_req_a", a_req, 1);
    check("rs2_req_b", b_req, 1);

    // Reset in the middle of a stall request.
    rst = 1'b1;
    #1;
    check("midrst_req",  a_req, 0);
    check("midrst_inst", a_inst, NOP);
    check("midrst_reqb", b_req, 0);
    #1 rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
